fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_ADDR, default 32'h00000000, is the PC value loaded on reset.
REQ-002 clock  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 pcOut  output  32  current PC, drives dataA of the PC+4 adder.
REQ-005 pcNext  input  32  adder result (pcOut+4), used as the sequential next PC.
REQ-006 branchTaken  input  1  redirect request, sampled each cycle.
REQ-007 branchTarget  input  32  redirect address, valid when branchTaken=1.
REQ-008 stall  input  1  downstream not ready; instruction is consumed when instrValid=1 and stall=0.
REQ-009 imemReq / imemAddr  output  1 / 32  instruction memory request and address.
REQ-010 imemAck / imemData  input  1 / 32  memory response strobe and word.
REQ-011 instrValid / instruction / instrPc  output  1 / 32 / 32  buffered instruction and its address.
REQ-012 fetchError  output  1  sticky misaligned-target flag.
REQ-013 fetchCount  output  16  count of instructions consumed downstream.

Function
REQ-014 States SHALL be START, REQ, DISCARD, FULL, ERROR; one-entry instruction buffer.
REQ-015 START: imemReq=0; next cycle -> REQ.
REQ-016 REQ: imemReq=1, imemAddr=pcOut; imemAddr SHALL stay stable while imemReq=1 and imemAck=0.
REQ-017 imemAck may arrive in the first REQ cycle or any later one; zero-wait and multi-wait responses SHALL both work.
REQ-018 Ack in REQ, no branch: buffer <= imemData, instrPc <= pcOut, pcOut <= pcNext, instrValid=1 next cycle.
REQ-019 After REQ-018 acceptance, if the buffer entry will be consumed in the same cycle as the ack (stall=0), next state REQ; otherwise FULL.
REQ-020 FULL: imemReq=0, instruction/instrPc held stable; on stall=0 consume, instrValid=0 next cycle, -> REQ.
REQ-021 branchTaken=1 SHALL have priority over stall and over sequential pcNext.
REQ-022 Branch in REQ without ack: latch target, -> DISCARD; DISCARD keeps imemReq=1 at old address until ack, drops imemData, then pcOut <= target, -> REQ.
REQ-023 Branch in REQ with ack same cycle: drop imemData, pcOut <= branchTarget, stay REQ.
REQ-024 Branch in FULL or START: invalidate buffer (instrValid=0 next cycle, not counted), pcOut <= branchTarget, -> REQ.
REQ-025 Second branch during DISCARD SHALL overwrite the latched target (last wins).
REQ-026 branchTarget[1:0] != 0 on an accepted branch: -> ERROR, fetchError=1, imemReq=0, instrValid=0, pcOut holds offending target; only reset exits ERROR (a pending ack is ignored).
REQ-027 pcNext SHALL be used unchecked (adder wraps 32'hFFFFFFFC -> 32'h00000000 naturally).
REQ-028 fetchCount SHALL increment by 1 on each consume cycle, wrap 16'hFFFF -> 16'h0000.

Reset
REQ-029 reset=0 SHALL immediately force: state START, pcOut=RESET_ADDR, imemReq=0, imemAddr=RESET_ADDR, instrValid=0, instruction=0, instrPc=0, fetchError=0, fetchCount=0.
REQ-030 Reset asserted mid-request SHALL abandon the request; any ack during or after reset before the next REQ is ignored.
REQ-031 First imemReq SHALL rise on the second rising edge after reset deasserts (START occupies one cycle).

Verification
REQ-032 Reset, stall=0, imemAck tied 1, imemData=addr: imemAddr sequence 0,4,8,C; instruction follows one cycle later; fetchCount=4 after 4 consumes.
REQ-033 Ack delayed 3 cycles at addr 8: imemAddr=8 stable all 3 cycles; single instruction delivered with instrPc=8.
REQ-034 stall=1 for 5 cycles while FULL with instr at 4: instruction/instrPc frozen, imemReq=0, fetchCount unchanged; stall=0 -> next imemAddr=8.
REQ-035 Branch to 32'h100 while waiting on addr C: word for C discarded (instrValid stays 0), next imemAddr=32'h100.
REQ-036 Branch to 32'h102: fetchError=1, imemReq=0 thereafter; reset=0 clears to pcOut=0, fetchError=0.
REQ-037 fetchCount preloaded to 16'hFFFF by 65535 consumes, one more consume -> 16'h0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Purpose : instruction fetch front end with a one-entry instruction buffer,
//           branch redirect, and a sticky misaligned-target error state.
// Latency : a memory word is presented on instrValid one cycle after its imemAck;
//           the first request is issued on the second clock edge after reset release.
// Backpressure: stall holds the buffered instruction; a word acked while the buffer
//           is still stalled is dropped and its address refetched after the drain.
//
// Ports:
//   clock, reset              clock and async active-low reset
//   pcOut / pcNext            current PC to the external +4 adder, adder result back
//   branchTaken/branchTarget  redirect request and address
//   stall                     downstream not ready (consume = instrValid & ~stall)
//   imemReq/imemAddr          memory request and address (address = PC)
//   imemAck/imemData          memory response strobe and word
//   instrValid/instruction/instrPc  buffered instruction and its address
//   fetchError                sticky misaligned-branch flag
//   fetchCount                instructions consumed downstream (wraps)
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] pcOut,
    input  logic [31:0] pcNext,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic        stall,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic        instrValid,
    output logic [31:0] instruction,
    output logic [31:0] instrPc,
    output logic        fetchError,
    output logic [15:0] fetchCount
);

    typedef enum logic [2:0] {
        START   = 3'd0,
        REQ     = 3'd1,
        DISCARD = 3'd2,
        FULL    = 3'd3,
        ERROR   = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] target_q;   // redirect address remembered while an old request drains
    logic        armed;      // START spends one full cycle after reset release

    logic consume;
    logic bad_branch;

    // A branch cycle never counts as a consume: the redirect kills the buffer entry.
    assign consume    = instrValid && !stall && !branchTaken;
    assign bad_branch = branchTaken && (branchTarget[1:0] != 2'b00) && (state != ERROR);

    // The memory address is always the current PC; it only moves on an ack or on
    // an error redirect (which also drops imemReq), so it is stable while waiting.
    assign pcOut    = pc;
    assign imemAddr = pc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= START;
            pc          <= RESET_ADDR;
            target_q    <= RESET_ADDR;
            armed       <= 1'b0;
            imemReq     <= 1'b0;
            instrValid  <= 1'b0;
            instruction <= 32'h0000_0000;
            instrPc     <= 32'h0000_0000;
            fetchError  <= 1'b0;
            fetchCount  <= 16'h0000;
        end else if (bad_branch) begin
            // Misaligned redirect: park with the offending target; only reset leaves.
            state      <= ERROR;
            fetchError <= 1'b1;
            imemReq    <= 1'b0;
            instrValid <= 1'b0;
            pc         <= branchTarget;
        end else begin
            if (consume) begin
                fetchCount <= fetchCount + 16'd1;
                instrValid <= 1'b0;
            end

            case (state)
                START: begin
                    if (branchTaken) begin
                        pc      <= branchTarget;
                        state   <= REQ;
                        imemReq <= 1'b1;
                    end else if (armed) begin
                        state   <= REQ;
                        imemReq <= 1'b1;
                    end else begin
                        armed <= 1'b1;
                    end
                end

                REQ: begin
                    if (branchTaken) begin
                        instrValid <= 1'b0;
                        if (imemAck) begin
                            // Response for the old path is dropped; fetch target next.
                            pc <= branchTarget;
                        end else begin
                            // Request still outstanding: let it finish, then redirect.
                            target_q <= branchTarget;
                            state    <= DISCARD;
                        end
                    end else if (imemAck) begin
                        // The word is only taken if the buffer is free or drains now;
                        // otherwise PC is left alone so the same word is fetched again.
                        if (!instrValid || !stall) begin
                            instruction <= imemData;
                            instrPc     <= pc;
                            pc          <= pcNext;
                            instrValid  <= 1'b1;
                        end
                        if (stall) begin
                            state   <= FULL;
                            imemReq <= 1'b0;
                        end
                    end
                end

                DISCARD: begin
                    if (imemAck) begin
                        pc    <= branchTaken ? branchTarget : target_q;
                        state <= REQ;
                    end else if (branchTaken) begin
                        target_q <= branchTarget;
                    end
                end

                FULL: begin
                    if (branchTaken) begin
                        instrValid <= 1'b0;
                        pc         <= branchTarget;
                        state      <= REQ;
                        imemReq    <= 1'b1;
                    end else if (!stall) begin
                        state   <= REQ;
                        imemReq <= 1'b1;
                    end
                end

                default: begin
                    // ERROR: hold everything until reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose : self-checking bench for fetch_unit with a memory responder, directed
//           scenarios and a randomized phase checked by an instruction-stream scoreboard.
// Latency : inputs change 2 time units after the rising edge, outputs are sampled there
//           or on the falling edge.
// Backpressure: stall and ack timing are driven by the stimulus and the responder.
module tb_fetch_unit;

    localparam logic [31:0] RST = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pcOut;
    logic [31:0] pcNext;
    logic        branchTaken = 1'b0;
    logic [31:0] branchTarget = 32'h0;
    logic        stall = 1'b0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        instrValid;
    logic [31:0] instruction;
    logic [31:0] instrPc;
    logic        fetchError;
    logic [15:0] fetchCount;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_ADDR(RST)) dut (
        .clock(clock), .reset(reset), .pcOut(pcOut), .pcNext(pcNext),
        .branchTaken(branchTaken), .branchTarget(branchTarget), .stall(stall),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
        .instrValid(instrValid), .instruction(instruction), .instrPc(instrPc),
        .fetchError(fetchError), .fetchCount(fetchCount)
    );

    always #5 clock = ~clock;

    // Memory contents: a fixed function of the address, distinct from the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    assign pcNext   = pcOut + 32'd4;
    assign imemData = mem_word(imemAddr);

    // Memory responder: optional wait states at one address, else tied or random ack.
    logic        rand_mode = 1'b0;
    logic        ack_level = 1'b1;
    logic [31:0] wait_addr = 32'hFFFF_FFFF;
    int          wait_left = 0;

    always @(posedge clock) begin
        #1;
        if (imemReq && imemAddr == wait_addr && wait_left > 0) begin
            imemAck = 1'b0;
            wait_left--;
        end else if (rand_mode) begin
            imemAck = ($urandom_range(0, 2) != 0);
        end else begin
            imemAck = ack_level;
        end
    end

    // Scoreboard. Stimulus pushes each issued redirect into redir_q. Reference rule:
    // the consumed stream starts at the reset address and each consumed instruction
    // sits 4 bytes after the previous one, unless a redirect was issued since the last
    // consume, in which case it is the most recent redirect target.
    logic        sb_en = 1'b0;
    logic [31:0] redir_q[$];
    logic [31:0] last_pc;
    logic [31:0] sb_exp;
    logic [15:0] model_cnt;
    int          n_consume = 0;
    logic        prev_ok = 1'b0;
    logic        prev_req, prev_ack, prev_v, prev_stall, prev_br;
    logic [31:0] prev_addr, prev_ins, prev_ipc;

    always @(negedge clock) begin
        if (!sb_en) begin
            prev_ok = 1'b0;
        end else begin
            checks++;
            if (fetchCount !== model_cnt) begin
                errors++;
                $display("FAIL sb_fetch_count act=%h exp=%h", fetchCount, model_cnt);
            end
            if (prev_ok && prev_req && !prev_ack && imemReq) begin
                checks++;
                if (imemAddr !== prev_addr) begin
                    errors++;
                    $display("FAIL sb_addr_stable act=%h exp=%h", imemAddr, prev_addr);
                end
            end
            if (prev_ok && prev_v && prev_stall && !prev_br) begin
                checks++;
                if (instrValid !== 1'b1 || instruction !== prev_ins || instrPc !== prev_ipc) begin
                    errors++;
                    $display("FAIL sb_buf_hold act=%b/%h/%h exp=1/%h/%h",
                             instrValid, instruction, instrPc, prev_ins, prev_ipc);
                end
            end
            if (instrValid && !stall && !branchTaken) begin
                if (redir_q.size() > 0) begin
                    sb_exp = redir_q[$];
                    redir_q.delete();
                end else begin
                    sb_exp = last_pc + 32'd4;
                end
                checks++;
                if (instrPc !== sb_exp || instruction !== mem_word(sb_exp)) begin
                    errors++;
                    $display("FAIL sb_consume act=%h/%h exp=%h/%h",
                             instrPc, instruction, sb_exp, mem_word(sb_exp));
                end
                last_pc = sb_exp;
                model_cnt++;
                n_consume++;
            end
            prev_ok    = 1'b1;
            prev_req   = imemReq;
            prev_ack   = imemAck;
            prev_addr  = imemAddr;
            prev_v     = instrValid;
            prev_stall = stall;
            prev_br    = branchTaken;
            prev_ins   = instruction;
            prev_ipc   = instrPc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic issue_branch(input logic [31:0] tgt);
        branchTaken  = 1'b1;
        branchTarget = tgt;
        if (tgt[1:0] == 2'b00) redir_q.push_back(tgt);
    endtask

    // Assert reset, check the forced values immediately, then release away from an edge.
    task automatic do_reset();
        sb_en        = 1'b0;
        reset        = 1'b0;
        branchTaken  = 1'b0;
        branchTarget = 32'h0;
        stall        = 1'b0;
        #1;
        chk("rst_pc", pcOut, RST);
        chk("rst_req", 32'(imemReq), 32'd0);
        chk("rst_addr", imemAddr, RST);
        chk("rst_vld", 32'(instrValid), 32'd0);
        chk("rst_ins", instruction, 32'd0);
        chk("rst_ipc", instrPc, 32'd0);
        chk("rst_err", 32'(fetchError), 32'd0);
        chk("rst_cnt", 32'(fetchCount), 32'd0);
        repeat (3) cyc();
        last_pc   = RST - 32'd4;
        model_cnt = 16'h0000;
        redir_q.delete();
        sb_en = 1'b1;
        reset = 1'b1;
    endtask

    int          n8, d8, cnt_c, n0;
    logic        found;
    logic [31:0] first_other;

    initial begin
        // Start-up timing and zero-wait sequential fetch.
        do_reset();
        cyc();
        chk("start_no_req", 32'(imemReq), 32'd0);
        cyc();
        chk("first_req", 32'(imemReq), 32'd1);
        chk("first_addr", imemAddr, 32'h0);
        for (int k = 1; k < 4; k++) begin
            cyc();
            chk("seq_addr", imemAddr, 32'(4 * k));
            chk("seq_vld", 32'(instrValid), 32'd1);
            chk("seq_ipc", instrPc, 32'(4 * (k - 1)));
            chk("seq_ins", instruction, mem_word(32'(4 * (k - 1))));
        end
        cyc();
        cyc();
        chk("seq_count4", 32'(fetchCount), 32'd4);

        // Three wait states at address 8.
        wait_addr = 32'h8;
        wait_left = 3;
        do_reset();
        n8 = 0;
        d8 = 0;
        for (int k = 0; k < 16; k++) begin
            cyc();
            if (imemReq && imemAddr == 32'h8) n8++;
            if (instrValid && !stall && instrPc == 32'h8) d8++;
        end
        chk("wait_addr8_cycles", 32'(n8), 32'd4);
        chk("wait_deliver8", 32'(d8), 32'd1);

        // Stall while the buffer holds the instruction from address 4.
        wait_addr = 32'h4;
        wait_left = 1;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cyc();
            if (imemReq && imemAddr == 32'h4 && imemAck && !instrValid) found = 1'b1;
        end
        chk("stall_setup", 32'(found), 32'd1);
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("stall_vld", 32'(instrValid), 32'd1);
            chk("stall_ipc", instrPc, 32'h4);
            chk("stall_ins", instruction, mem_word(32'h4));
            chk("stall_req", 32'(imemReq), 32'd0);
            chk("stall_cnt", 32'(fetchCount), 32'd1);
        end
        stall = 1'b0;
        cyc();
        chk("unstall_req", 32'(imemReq), 32'd1);
        chk("unstall_addr", imemAddr, 32'h8);
        chk("unstall_cnt", 32'(fetchCount), 32'd2);

        // Redirect while waiting on address C: the C word must never appear.
        wait_addr = 32'hC;
        wait_left = 3;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cyc();
            if (imemReq && imemAddr == 32'hC && !imemAck && !instrValid) found = 1'b1;
        end
        chk("discard_setup", 32'(found), 32'd1);
        issue_branch(32'h100);
        cyc();
        branchTaken = 1'b0;
        cnt_c       = 0;
        first_other = 32'hFFFF_FFFF;
        for (int k = 0; k < 10; k++) begin
            if (imemReq && imemAddr != 32'hC && first_other == 32'hFFFF_FFFF) first_other = imemAddr;
            if (instrValid && instrPc == 32'hC) cnt_c++;
            cyc();
        end
        chk("discard_next_addr", first_other, 32'h100);
        chk("discard_no_c", 32'(cnt_c), 32'd0);
        wait_addr = 32'hFFFF_FFFF;

        // Misaligned redirect, then reset clears the error.
        do_reset();
        repeat (4) cyc();
        issue_branch(32'h102);
        cyc();
        branchTaken = 1'b0;
        chk("err_flag", 32'(fetchError), 32'd1);
        chk("err_req", 32'(imemReq), 32'd0);
        chk("err_pc", pcOut, 32'h102);
        chk("err_vld", 32'(instrValid), 32'd0);
        rand_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            issue_branch(32'h200);
            cyc();
            chk("err_sticky_req", 32'(imemReq), 32'd0);
            chk("err_sticky_pc", pcOut, 32'h102);
        end
        branchTaken = 1'b0;
        do_reset();
        rand_mode = 1'b0;
        cyc();

        // Randomized traffic: random acks, stalls and aligned redirects.
        rand_mode = 1'b1;
        do_reset();
        n0 = n_consume;
        for (int k = 0; k < 3000; k++) begin
            cyc();
            stall = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 19) == 0) issue_branch(32'($urandom_range(0, 255)) << 2);
            else branchTaken = 1'b0;
        end
        branchTaken = 1'b0;
        stall       = 1'b0;
        chk("rand_progress", 32'((n_consume - n0) > 200), 32'd1);
        // Reset in the middle of random traffic; stray acks must not leak through.
        do_reset();
        n0 = n_consume;
        repeat (40) cyc();
        chk("post_reset_progress", 32'((n_consume - n0) > 5), 32'd1);

        // Counter wrap.
        rand_mode = 1'b0;
        ack_level = 1'b1;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 70000 && !found; k++) begin
            cyc();
            if (fetchCount == 16'hFFFF) found = 1'b1;
        end
        chk("wrap_reach_ffff", 32'(found), 32'd1);
        chk("wrap_consume_pending", 32'(instrValid), 32'd1);
        cyc();
        chk("wrap_zero", 32'(fetchCount), 32'd0);

        sb_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
